// File: rtl/cf_ifft_1024_8_8_if.sv
// cf_ifft_1024_8_8_if: sample/twiddle/enable inputs and recovered-pair outputs
// of the inverse radix-2 butterfly.
interface cf_ifft_1024_8_8_if;
   logic [15:0] i1;
   logic [15:0] i2;
   logic [1:0]  i3;
   logic        i4;
   logic        i6;
   logic [15:0] o1;
   logic [15:0] o2;
   logic        o3;
   modport master (output i1, i2, i3, i4, i6, input o1, o2, o3);
   modport slave  (input i1, i2, i3, i4, i6, output o1, o2, o3);
endinterface

// File: rtl/cf_ifft_1024_8_8.sv
// cf_ifft_1024_8_8: inverse radix-2 butterfly, A=(X+Y)/2, B=((X-Y)/2)*conj(W),
// three enabled stages with valid tracking and asynchronous reset.
module cf_ifft_1024_8_8 (
   input logic clock_c,
   input logic i5,
   cf_ifft_1024_8_8_if.slave bus
);
   // halved sum at 9 bits, floor shift keeps the result within 8 bits
   function automatic logic [7:0] half_add(input logic [7:0] a, input logic [7:0] b, input logic sub);
      logic [8:0] t;
      t = sub ? {a[7], a} - {b[7], b} : {a[7], a} + {b[7], b};
      return 8'(t >> 1);
   endfunction
   // Q1.7 product, bits [14:7] of the 16-bit signed result
   function automatic logic [7:0] mul_q(input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] p;
      p = $signed(a) * $signed(b);
      return 8'(p >>> 7);
   endfunction
   logic [15:0] w_c, s1_s, s1_d, s1_w, s2_s, a_q, b_q;
   logic [7:0]  p_rr, p_ii, p_ri, p_ir;
   logic        v1, v2, v3;
   always_comb
      w_c = bus.i3 == 2'd0 ? 16'h7F00 :
            bus.i3 == 2'd1 ? 16'h5A5B :
            bus.i3 == 2'd2 ? 16'h007F : 16'hA55B;
   always_ff @(posedge clock_c or posedge i5) begin
      if (i5) begin
         {s1_s, s1_d, s1_w, v1} <= '0;
         {s2_s, p_rr, p_ii, p_ri, p_ir, v2} <= '0;
         {a_q, b_q, v3} <= '0;
      end else if (bus.i4) begin
         s1_s <= {half_add(bus.i1[15:8], bus.i2[15:8], 1'b0), half_add(bus.i1[7:0], bus.i2[7:0], 1'b0)};
         s1_d <= {half_add(bus.i1[15:8], bus.i2[15:8], 1'b1), half_add(bus.i1[7:0], bus.i2[7:0], 1'b1)};
         s1_w <= w_c;
         v1   <= bus.i6;
         s2_s <= s1_s;
         p_rr <= mul_q(s1_d[15:8], s1_w[15:8]);
         p_ii <= mul_q(s1_d[7:0], s1_w[7:0]);
         p_ri <= mul_q(s1_d[15:8], s1_w[7:0]);
         p_ir <= mul_q(s1_d[7:0], s1_w[15:8]);
         v2   <= v1;
         a_q  <= s2_s;
         b_q  <= {p_rr - p_ii, p_ri + p_ir};
         v3   <= v2;
      end
   end
   assign bus.o1 = a_q;
   assign bus.o2 = b_q;
   assign bus.o3 = v3;
endmodule

// File: tb/tb_cf_ifft_1024_8_8.sv
// tb_cf_ifft_1024_8_8: directed vectors with hand-computed results for the
// inverse butterfly: reset, extremes, stall, async reset and a twiddle stream.
module tb_cf_ifft_1024_8_8;
   logic clock_c = 1'b0;
   logic i5 = 1'b1;
   int tests = 0;
   int fails = 0;
   cf_ifft_1024_8_8_if bus ();
   cf_ifft_1024_8_8 dut (.clock_c(clock_c), .i5(i5), .bus(bus));
   always #5 clock_c = ~clock_c;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [1:0] w, input logic v);
      bus.i1 = x;
      bus.i2 = y;
      bus.i3 = w;
      bus.i6 = v;
      @(posedge clock_c);
      #1;
   endtask

   task automatic run(input string tag, input logic [15:0] x, input logic [15:0] y, input logic [1:0] w,
                      input logic [15:0] ea, input logic [15:0] eb);
      send(x, y, w, 1'b1);
      chk({tag, "_v1"}, {15'd0, bus.o3}, 16'd0);
      send(16'h0, 16'h0, 2'd0, 1'b0);
      send(16'h0, 16'h0, 2'd0, 1'b0);
      chk({tag, "_a"}, bus.o1, ea);
      chk({tag, "_b"}, bus.o2, eb);
      chk({tag, "_v3"}, {15'd0, bus.o3}, 16'd1);
      send(16'h0, 16'h0, 2'd0, 1'b0);
      chk({tag, "_v4"}, {15'd0, bus.o3}, 16'd0);
   endtask

   initial begin
      bus.i1 = '0; bus.i2 = '0; bus.i3 = '0; bus.i4 = 1'b1; bus.i6 = 1'b0;
      #1;
      chk("rst_a", bus.o1, 16'h0);
      chk("rst_b", bus.o2, 16'h0);
      chk("rst_v", {15'd0, bus.o3}, 16'd0);
      @(posedge clock_c);
      #1 i5 = 1'b0;
      run("w00", 16'h2814, 16'h14F6, 2'd0, 16'h1E05, 16'h090E);
      run("w10", 16'h4000, 16'h0000, 2'd2, 16'h2000, 16'h001F);
      run("ext", 16'h8080, 16'h7F7F, 2'd0, 16'hFFFF, 16'h8181);
      run("eq", 16'h7F7F, 16'h7F7F, 2'd0, 16'h7F7F, 16'h0000);
      // stall two cycles with the sample mid-pipe
      send(16'h2814, 16'h14F6, 2'd0, 1'b1);
      bus.i4 = 1'b0;
      send(16'h0, 16'h0, 2'd0, 1'b0);
      send(16'h0, 16'h0, 2'd0, 1'b0);
      chk("stall_v0", {15'd0, bus.o3}, 16'd0);
      bus.i4 = 1'b1;
      send(16'h0, 16'h0, 2'd0, 1'b0);
      chk("stall_v1", {15'd0, bus.o3}, 16'd0);
      send(16'h0, 16'h0, 2'd0, 1'b0);
      chk("stall_a", bus.o1, 16'h1E05);
      chk("stall_b", bus.o2, 16'h090E);
      chk("stall_v", {15'd0, bus.o3}, 16'd1);
      bus.i4 = 1'b0;
      send(16'h0, 16'h0, 2'd0, 1'b0);
      send(16'h0, 16'h0, 2'd0, 1'b0);
      chk("hold_a", bus.o1, 16'h1E05);
      chk("hold_b", bus.o2, 16'h090E);
      chk("hold_v", {15'd0, bus.o3}, 16'd1);
      bus.i4 = 1'b1;
      // async reset between edges discards in-flight samples
      send(16'h2814, 16'h14F6, 2'd0, 1'b1);
      send(16'h2814, 16'h14F6, 2'd0, 1'b1);
      #2 i5 = 1'b1;
      #1;
      chk("arst_a", bus.o1, 16'h0);
      chk("arst_b", bus.o2, 16'h0);
      chk("arst_v", {15'd0, bus.o3}, 16'd0);
      @(posedge clock_c);
      #1 i5 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         send(16'h0, 16'h0, 2'd0, 1'b0);
         chk("arst_flush", {15'd0, bus.o3}, 16'd0);
      end
      // back-to-back stream, one twiddle per sample
      send(16'h2814, 16'h14F6, 2'd0, 1'b1);
      send(16'h2814, 16'h14F6, 2'd1, 1'b1);
      send(16'h2814, 16'h14F6, 2'd2, 1'b1);
      chk("s0_a", bus.o1, 16'h1E05);
      chk("s0_b", bus.o2, 16'h090E);
      chk("s0_v", {15'd0, bus.o3}, 16'd1);
      send(16'h2814, 16'h14F6, 2'd3, 1'b1);
      chk("s1_b", bus.o2, 16'hFD11);
      chk("s1_v", {15'd0, bus.o3}, 16'd1);
      send(16'h0, 16'h0, 2'd0, 1'b0);
      chk("s2_b", bus.o2, 16'hF209);
      chk("s2_v", {15'd0, bus.o3}, 16'd1);
      send(16'h0, 16'h0, 2'd0, 1'b0);
      chk("s3_a", bus.o1, 16'h1E05);
      chk("s3_b", bus.o2, 16'hEEFC);
      chk("s3_v", {15'd0, bus.o3}, 16'd1);
      send(16'h0, 16'h0, 2'd0, 1'b0);
      chk("s4_v", {15'd0, bus.o3}, 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cf_ifft_1024_8_8.md
Name: cf_ifft_1024_8_8

Overview:
- Inverse radix-2 butterfly for the 8-bit complex FFT datapath. It is the decode direction of the forward butterfly.
- Takes a butterfly output pair X = A + B·W and Y = A − B·W. Recovers A = (X+Y)/2 and B = ((X−Y)/2)·conj(W).
- Three-stage pipeline with a global enable, a valid-tracking pipeline and asynchronous reset.
- Sits in the IFFT path that undoes forward FFT stages.

Parameters:
- none (widths fixed: 8-bit signed components, Q1.7 twiddles, 16-bit packed {re,im} words)

Ports:
- clock_c  input  1   clock; all registers update on its rising edge
- i5  input  1   asynchronous active-high reset
- i1  input  16  X sample, {re[15:8], im[7:0]}, two's complement
- i2  input  16  Y sample, same format
- i3  input  2   twiddle select, sampled together with i1/i2
- i4  input  1   pipeline enable; registers advance only when 1
- i6  input  1   input valid, sampled with i1/i2 when i4=1
- o1  output 16  recovered A, {re, im}
- o2  output 16  recovered B, {re, im}
- o3  output 1   output valid, aligned with o1/o2

Behaviour:
- Reset:
  - i5=1 asynchronously clears every data register, every twiddle register and every valid bit to 0.
  - o1=0x0000, o2=0x0000 and o3=0 immediately, without waiting for a clock edge.
  - Reset has priority over i4.
  - Reset mid-stream discards all in-flight samples.
- Enable:
  - i4=0: every register, including valids and outputs, holds.
  - i4=1: all stages advance together.
- Latency: exactly 3 enabled clock edges from i1/i2/i3/i6 to o1/o2/o3. Stalled cycles do not count.
- Conjugate twiddle table, Q1.7, {re, im}, registered in stage 1:
  - 00 -> 0x7F00 (127, 0)
  - 01 -> 0x5A5B (90, 91)
  - 10 -> 0x007F (0, 127)
  - 11 -> 0xA55B (-91, 91)
- Stage 1:
  - S = (X+Y)>>>1 and D = (X−Y)>>>1, per component.
  - Compute at 9 bits, then arithmetic shift right (floor). Results always fit in 8 bits, no saturation.
  - Register S, D, the twiddle and the valid.
- Stage 2:
  - Four signed 8x8 products, each sign-extended to 16 bits: Dr·Wr, Di·Wi, Dr·Wi, Di·Wr.
  - Keep product bits [14:7] (truncate, floor), then register.
  - Delay S one stage alongside.
- Stage 3:
  - Br = (Dr·Wr) − (Di·Wi)
  - Bi = (Dr·Wi) + (Di·Wr)
  - Both are 8-bit modulo (wrap, no saturation).
  - Register o2 = {Br, Bi}, o1 = S and o3 = delayed valid.
- Valid handling:
  - Data registers advance whenever i4=1, regardless of i6.
  - o1/o2 content is meaningful only when o3=1.
- Twiddle alignment:
  - Each sample uses the twiddle sampled in its own cycle.
  - Changing i3 every enabled cycle is legal.

Test Plan:
- Async reset: assert i5 between clock edges mid-stream -> o1=0x0000, o2=0x0000, o3=0 before the next edge. Release i5 -> o3 stays 0 until 3 enabled edges after the next valid input.
- i3=00, X=0x2814 (40,20), Y=0x14F6 (20,−10), i6=1 -> after 3 enabled edges: o1=0x1E05, o2=0x090E, o3=1 for one cycle.
- i3=10, X=0x4000, Y=0x0000 -> o1=0x2000, o2=0x001F.
- Extremes, i3=00:
  - X=0x8080, Y=0x7F7F -> o1=0xFFFF, o2=0x8181.
  - X=Y=0x7F7F -> o1=0x7F7F, o2=0x0000.
- Stall: drive a valid sample, drop i4 for 2 cycles while it is mid-pipe -> o1/o2/o3 hold. The result appears on the 3rd enabled edge, not earlier.
- Back-to-back stream: 4 consecutive valid samples with i3 = 00, 01, 10, 11 -> each output matches a reference model using its own twiddle. o3 is high for 4 consecutive enabled cycles.
